// File: rtl/game_pkg.sv
// Shared definitions for the game-setup register reader.
// Register map, index enum, reader states and bench helpers.
package game_pkg;

    localparam logic [7:0] ADDR_ROW_COL     = 8'h00;
    localparam logic [7:0] ADDR_MINE_NUM    = 8'h02;
    localparam logic [7:0] ADDR_TIMER       = 8'h04;
    localparam logic [7:0] ADDR_FIELD_SIZE  = 8'h06;
    localparam logic [7:0] ADDR_BOARD_SIZE  = 8'h08;
    localparam logic [7:0] ADDR_BOARD_XPOS  = 8'h0A;
    localparam logic [7:0] ADDR_BOARD_YPOS  = 8'h0C;
    localparam logic [7:0] ADDR_GAMES_WON   = 8'h0E;
    localparam logic [7:0] ADDR_GAMES_LOST  = 8'h10;

    typedef enum logic [3:0] {
        IDX_ROW_COL     = 4'd0,
        IDX_MINE_NUM    = 4'd1,
        IDX_TIMER       = 4'd2,
        IDX_FIELD_SIZE  = 4'd3,
        IDX_BOARD_SIZE  = 4'd4,
        IDX_BOARD_XPOS  = 4'd5,
        IDX_BOARD_YPOS  = 4'd6,
        IDX_GAMES_WON   = 4'd7,
        IDX_GAMES_LOST  = 4'd8
    } reg_idx_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ACK,
        ST_DONE
    } reader_state_e;

    // Value a bench slave returns for unmapped addresses.
    localparam logic [15:0] DEAD = 16'hDEAD;

`ifdef GAME_SETUP_STATS_EN
    localparam int NUM_REGS = 9;
`else
    localparam int NUM_REGS = 7;
`endif

    localparam logic [3:0] LAST_IDX = 4'(NUM_REGS - 1);

    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        logic [7:0] a;
        a = ADDR_ROW_COL;
        unique case (idx)
            IDX_ROW_COL:    a = ADDR_ROW_COL;
            IDX_MINE_NUM:   a = ADDR_MINE_NUM;
            IDX_TIMER:      a = ADDR_TIMER;
            IDX_FIELD_SIZE: a = ADDR_FIELD_SIZE;
            IDX_BOARD_SIZE: a = ADDR_BOARD_SIZE;
            IDX_BOARD_XPOS: a = ADDR_BOARD_XPOS;
            IDX_BOARD_YPOS: a = ADDR_BOARD_YPOS;
            IDX_GAMES_WON:  a = ADDR_GAMES_WON;
            IDX_GAMES_LOST: a = ADDR_GAMES_LOST;
            default:        a = ADDR_ROW_COL;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// Pipelined Wishbone read/write bundle used by the setup reader.
// Master drives strobe/address, slave returns stall/ack/data.
interface wishbone_if;

    logic        stb_o;
    logic        we_o;
    logic [7:0]  adr_o;
    logic        stall_i;
    logic        ack_i;
    logic [15:0] dat_i;

    modport master (
        output stb_o,
        output we_o,
        output adr_o,
        input  stall_i,
        input  ack_i,
        input  dat_i
    );

    modport slave (
        input  stb_o,
        input  we_o,
        input  adr_o,
        output stall_i,
        output ack_i,
        output dat_i
    );

endinterface

// File: rtl/wb_timeout_cnt.sv
// Per-transfer watchdog for the setup reader.
// expired is high in the TIMEOUT_CYCLES-th enabled cycle after clear.
module wb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [15:0] cnt_q;

    // Count outstanding cycles, saturating so a stuck enable cannot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign expired = en && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/game_setup_reader.sv
// Wishbone sweep reader for the game-setup register bank.
// Define GAME_SETUP_STATS_EN to also fetch games_won/games_lost.
module game_setup_reader
    import game_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    wishbone_if.master  wb,
    output logic [15:0] row_column_number,
    output logic [15:0] mine_num,
    output logic [15:0] timer_seconds,
    output logic [15:0] field_size,
    output logic [15:0] board_size,
    output logic [15:0] board_xpos,
    output logic [15:0] board_ypos,
    output logic [15:0] games_won,
    output logic [15:0] games_lost,
    output logic        busy,
    output logic        done,
    output logic        valid,
    output logic        err
);

    reader_state_e state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic          capture;
    logic          cnt_clr;
    logic          cnt_en;
    logic          expired;
    logic          timeout;
    logic          accept_start;
    logic [15:0]   data_q [NUM_REGS];

    assign cnt_en       = (state_q == ST_REQ) || (state_q == ST_WAIT_ACK);
    assign accept_start = (state_q == ST_IDLE) && start;

    wb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .expired(expired)
    );

    // Next-state logic; a late ack wins over a same-cycle expiry.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        capture = 1'b0;
        cnt_clr = 1'b0;
        timeout = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                    idx_d   = '0;
                    cnt_clr = 1'b1;
                end
            end
            ST_REQ: begin
                if (!wb.stall_i) begin
                    state_d = ST_WAIT_ACK;
                end else if (expired) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_WAIT_ACK: begin
                if (wb.ack_i) begin
                    capture = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_REQ;
                        idx_d   = idx_q + 4'd1;
                        cnt_clr = 1'b1;
                    end
                end else if (expired) begin
                    state_d = ST_IDLE;
                    timeout = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and read-index registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Bus and status outputs are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb.stb_o <= 1'b0;
            wb.we_o  <= 1'b0;
            wb.adr_o <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            wb.stb_o <= (state_d == ST_REQ);
            wb.we_o  <= 1'b0;
            wb.adr_o <= reg_addr(idx_d);
            busy     <= (state_d == ST_REQ) ||
                        (state_d == ST_WAIT_ACK);
            done     <= (state_d == ST_DONE);
            if (accept_start) begin
                valid <= 1'b0;
                err   <= 1'b0;
            end
            if (state_d == ST_DONE) begin
                valid <= 1'b1;
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

    // Capture read data into the slot of the current index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (capture && idx_q == 4'(i)) begin
                    data_q[i] <= wb.dat_i;
                end
            end
        end
    end

    assign row_column_number = data_q[int'(IDX_ROW_COL)];
    assign mine_num          = data_q[int'(IDX_MINE_NUM)];
    assign timer_seconds     = data_q[int'(IDX_TIMER)];
    assign field_size        = data_q[int'(IDX_FIELD_SIZE)];
    assign board_size        = data_q[int'(IDX_BOARD_SIZE)];
    assign board_xpos        = data_q[int'(IDX_BOARD_XPOS)];
    assign board_ypos        = data_q[int'(IDX_BOARD_YPOS)];

`ifdef GAME_SETUP_STATS_EN
    assign games_won  = data_q[int'(IDX_GAMES_WON)];
    assign games_lost = data_q[int'(IDX_GAMES_LOST)];
`else
    assign games_won  = '0;
    assign games_lost = '0;
`endif

endmodule

// File: tb/tb_game_setup_reader.sv
// Self-checking bench for game_setup_reader.
// Random register contents checked against a register-bank model.
`timescale 1ns/1ps
module tb_game_setup_reader;
    import game_pkg::*;

`ifdef GAME_SETUP_STATS_EN
    localparam int NREADS = 9;
`else
    localparam int NREADS = 7;
`endif
    localparam int TMO = 64;

    typedef struct {
        logic        stb;
        logic [7:0]  adr;
        logic        err;
        logic        valid;
        logic        busy;
        logic [15:0] row;
    } tr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [15:0] row_column_number, mine_num, timer_seconds;
    logic [15:0] field_size, board_size, board_xpos, board_ypos;
    logic [15:0] games_won, games_lost;
    logic busy, done, valid, err;

    int n_checks = 0;
    int n_fail = 0;

    logic [15:0] mem [9];
    logic [15:0] model [9];
    int stall_left = 0;
    bit stall_hold = 1'b0;
    int spur_left = 0;

    logic [7:0] addr_q [$];
    int acyc_q [$];
    tr_t tr_q [$];

    wishbone_if wb();

    game_setup_reader #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .wb(wb.master),
        .row_column_number(row_column_number),
        .mine_num(mine_num),
        .timer_seconds(timer_seconds),
        .field_size(field_size),
        .board_size(board_size),
        .board_xpos(board_xpos),
        .board_ypos(board_ypos),
        .games_won(games_won),
        .games_lost(games_lost),
        .busy(busy),
        .done(done),
        .valid(valid),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] slave_rd(input logic [7:0] a);
        if (a[0] == 1'b0 && a <= 8'h10) return mem[int'(a) / 2];
        return DEAD;
    endfunction

    function automatic logic [143:0] outs_cat();
        return {row_column_number, mine_num, timer_seconds,
                field_size, board_size, board_xpos, board_ypos,
                games_won, games_lost};
    endfunction

    function automatic logic [143:0] model_cat();
        return {model[0], model[1], model[2], model[3], model[4],
                model[5], model[6], model[7], model[8]};
    endfunction

    function automatic logic [12:0] ctl_cat();
        return {busy, done, valid, err, wb.stb_o, wb.we_o, wb.adr_o};
    endfunction

    // Pipelined slave: ack one cycle after an unstalled strobe.
    initial begin : slave
        logic acc;
        logic [7:0] a;
        wb.stall_i = 1'b0;
        wb.ack_i = 1'b0;
        wb.dat_i = 16'h0;
        forever begin
            @(negedge clk);
            acc = wb.stb_o && !wb.stall_i;
            a = wb.adr_o;
            @(posedge clk);
            #1;
            wb.ack_i = acc || (spur_left > 0);
            wb.dat_i = acc ? slave_rd(a) :
                       (spur_left > 0) ? 16'h1234 : 16'h0000;
            if (spur_left > 0 && !acc) spur_left--;
            wb.stall_i = stall_hold || (stall_left > 0);
            if (stall_left > 0) stall_left--;
        end
    end

    task automatic new_mem(input bit fixed);
        for (int i = 0; i < 9; i++) begin
            mem[i] = fixed ? 16'(9 + i) : 16'($urandom);
        end
    endtask

    task automatic model_sweep_ok();
        for (int i = 0; i < NREADS; i++) model[i] = mem[i];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 9; i++) model[i] = 16'h0;
    endtask

    // Starts a sweep from cycle 0 and records per-cycle activity.
    task automatic do_sweep(input int stall0, input int inj,
                            input int spur0, output int done_at,
                            output int n_done, output logic v_at);
        tr_t t;
        addr_q.delete();
        acyc_q.delete();
        tr_q.delete();
        done_at = -1;
        n_done = 0;
        v_at = 1'b0;
        stall_left = stall0;
        spur_left = spur0;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            t.stb = wb.stb_o;
            t.adr = wb.adr_o;
            t.err = err;
            t.valid = valid;
            t.busy = busy;
            t.row = row_column_number;
            tr_q.push_back(t);
            if (wb.stb_o && !wb.stall_i) begin
                addr_q.push_back(wb.adr_o);
                acyc_q.push_back(k);
            end
            if (done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at = k;
                    v_at = valid;
                end
            end
            start = (k == inj);
            if (done_at >= 0 && k >= done_at + 2) break;
            @(posedge clk);
            #2;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        model_reset();
        n_checks++;
        if (ctl_cat() !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %h want 0", ctl_cat());
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #2;
            n_checks++;
            if (outs_cat() !== model_cat()) begin
                n_fail++;
                $display("FAIL idle_data c%0d: got %h want %h",
                         k, outs_cat(), model_cat());
            end
            n_checks++;
            if (ctl_cat() !== 13'h0) begin
                n_fail++;
                $display("FAIL idle_ctl c%0d: got %h want 0",
                         k, ctl_cat());
            end
        end
    endtask

    task automatic test_easy_sweep();
        int da, nd;
        logic va;
        new_mem(1'b1);
        do_sweep(0, 0, 0, da, nd, va);
        model_sweep_ok();
        n_checks++;
        if (addr_q.size() !== NREADS) begin
            n_fail++;
            $display("FAIL easy_nreads: got %0d want %0d",
                     addr_q.size(), NREADS);
        end
        for (int i = 0; i < addr_q.size() && i < NREADS; i++) begin
            n_checks++;
            if (addr_q[i] !== 8'(2 * i) || acyc_q[i] !== 2 * i + 1) begin
                n_fail++;
                $display("FAIL easy_addr %0d: got %h@%0d want %h@%0d",
                         i, addr_q[i], acyc_q[i], 8'(2 * i), 2 * i + 1);
            end
        end
        n_checks++;
        if (da !== 2 * NREADS + 1 || nd !== 1) begin
            n_fail++;
            $display("FAIL easy_done: got %0d x%0d want %0d x1",
                     da, nd, 2 * NREADS + 1);
        end
        n_checks++;
        if (va !== 1'b1 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL easy_valid: got %b/%b want 1/1", va, valid);
        end
        n_checks++;
        if (row_column_number !== 16'h0009) begin
            n_fail++;
            $display("FAIL easy_row: got %h want 0009",
                     row_column_number);
        end
        n_checks++;
        if (outs_cat() !== model_cat()) begin
            n_fail++;
            $display("FAIL easy_data: got %h want %h",
                     outs_cat(), model_cat());
        end
    endtask

    task automatic test_stall();
        int da, nd;
        logic va;
        new_mem(1'b0);
        do_sweep(5, 0, 0, da, nd, va);
        model_sweep_ok();
        for (int k = 1; k <= 5; k++) begin
            n_checks++;
            if (tr_q[k - 1].stb !== 1'b1 || tr_q[k - 1].adr !== 8'h00) begin
                n_fail++;
                $display("FAIL stall_hold c%0d: got %b/%h want 1/00",
                         k, tr_q[k - 1].stb, tr_q[k - 1].adr);
            end
        end
        n_checks++;
        if (acyc_q.size() == 0 || acyc_q[0] !== 6) begin
            n_fail++;
            $display("FAIL stall_accept: got %0d want 6",
                     acyc_q.size() == 0 ? -1 : acyc_q[0]);
        end
        n_checks++;
        if (da !== 2 * NREADS + 6 || nd !== 1 || va !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_done: got %0d x%0d v%b want %0d x1 v1",
                     da, nd, va, 2 * NREADS + 6);
        end
        n_checks++;
        if (outs_cat() !== model_cat()) begin
            n_fail++;
            $display("FAIL stall_data: got %h want %h",
                     outs_cat(), model_cat());
        end
    endtask

    task automatic test_timeout();
        int hi;
        int da, nd;
        logic va;
        hi = 0;
        stall_hold = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            if (wb.stb_o === 1'b1 && wb.adr_o === 8'h00) hi++;
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (hi !== TMO) begin
            n_fail++;
            $display("FAIL tmo_stb_cycles: got %0d want %0d", hi, TMO);
        end
        n_checks++;
        if ({wb.stb_o, busy, err, valid, done} !== 5'b00100) begin
            n_fail++;
            $display("FAIL tmo_abort: got stb,busy,err,valid,done=%b want 00100",
                     {wb.stb_o, busy, err, valid, done});
        end
        n_checks++;
        if (outs_cat() !== model_cat()) begin
            n_fail++;
            $display("FAIL tmo_data: got %h want %h",
                     outs_cat(), model_cat());
        end
        stall_hold = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_sticky: got %b want 1", err);
        end
        new_mem(1'b0);
        do_sweep(0, 0, 0, da, nd, va);
        model_sweep_ok();
        n_checks++;
        if (tr_q[0].err !== 1'b0 || tr_q[0].valid !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_clear: got err %b valid %b want 0 0",
                     tr_q[0].err, tr_q[0].valid);
        end
        n_checks++;
        if (da !== 2 * NREADS + 1 || va !== 1'b1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL tmo_recover: got %0d v%b e%b want %0d v1 e0",
                     da, va, err, 2 * NREADS + 1);
        end
    endtask

    task automatic test_reset_mid();
        new_mem(1'b0);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            @(posedge clk);
            #2;
        end
        n_checks++;
        if (row_column_number !== mem[0] || wb.adr_o !== 8'h04) begin
            n_fail++;
            $display("FAIL mid_progress: got %h@%h want %h@04",
                     row_column_number, wb.adr_o, mem[0]);
        end
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (outs_cat() !== model_cat() || ctl_cat() !== 13'h0) begin
            n_fail++;
            $display("FAIL mid_rst: got %h/%h want all 0",
                     outs_cat(), ctl_cat());
        end
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (outs_cat() !== model_cat() || ctl_cat() !== 13'h0) begin
            n_fail++;
            $display("FAIL mid_after: got %h/%h want all 0",
                     outs_cat(), ctl_cat());
        end
    endtask

    task automatic test_start_busy();
        int da, nd;
        logic va;
        new_mem(1'b0);
        do_sweep(0, 4, 0, da, nd, va);
        model_sweep_ok();
        n_checks++;
        if (addr_q.size() !== NREADS) begin
            n_fail++;
            $display("FAIL busy_nreads: got %0d want %0d",
                     addr_q.size(), NREADS);
        end
        for (int i = 0; i < addr_q.size() && i < NREADS; i++) begin
            n_checks++;
            if (addr_q[i] !== 8'(2 * i) || acyc_q[i] !== 2 * i + 1) begin
                n_fail++;
                $display("FAIL busy_addr %0d: got %h@%0d want %h@%0d",
                         i, addr_q[i], acyc_q[i], 8'(2 * i), 2 * i + 1);
            end
        end
        n_checks++;
        if (da !== 2 * NREADS + 1 || nd !== 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_done: got %0d x%0d b%b want %0d x1 b0",
                     da, nd, busy, 2 * NREADS + 1);
        end
        n_checks++;
        if (outs_cat() !== model_cat()) begin
            n_fail++;
            $display("FAIL busy_data: got %h want %h",
                     outs_cat(), model_cat());
        end
    endtask

    task automatic test_spurious_ack();
        int da, nd;
        logic va;
        logic [15:0] old_row;
        spur_left = 2;
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (outs_cat() !== model_cat() || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL spur_idle: got %h v%b want %h v1",
                     outs_cat(), valid, model_cat());
        end
        old_row = model[0];
        new_mem(1'b0);
        do_sweep(4, 0, 3, da, nd, va);
        model_sweep_ok();
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if (tr_q[k - 1].row !== old_row) begin
                n_fail++;
                $display("FAIL spur_req c%0d: got %h want %h",
                         k, tr_q[k - 1].row, old_row);
            end
        end
        n_checks++;
        if (da !== 2 * NREADS + 5 || nd !== 1) begin
            n_fail++;
            $display("FAIL spur_done: got %0d x%0d want %0d x1",
                     da, nd, 2 * NREADS + 5);
        end
        n_checks++;
        if (outs_cat() !== model_cat()) begin
            n_fail++;
            $display("FAIL spur_data: got %h want %h",
                     outs_cat(), model_cat());
        end
    endtask

    task automatic test_back_to_back();
        int da, nd;
        logic va;
        for (int r = 0; r < 3; r++) begin
            new_mem(1'b0);
            do_sweep(int'($urandom_range(0, 3)), 0, 0, da, nd, va);
            model_sweep_ok();
            n_checks++;
            if (outs_cat() !== model_cat() || va !== 1'b1 || nd !== 1) begin
                n_fail++;
                $display("FAIL b2b %0d: got %h v%b x%0d want %h v1 x1",
                         r, outs_cat(), va, nd, model_cat());
            end
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_easy_sweep();
        test_stall();
        test_timeout();
        test_start_busy();
        test_spurious_ack();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
